// File: rtl/param_arith_unit.sv
// param_arith_unit
//   Registered WIDTH-bit arithmetic unit. It computes A-1, A+B, A-B or -B with a
//   single adder and returns carry, signed-overflow, zero and negative flags.
//   Operands arrive on a valid/ready handshake, and results leave on a second
//   valid/ready handshake. The unit has one output register and no skid buffer.
//   With acc_en set, the last accepted result (acc) is used in place of in_a.
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   s1,s0               op select: 00 A-1, 01 A+B, 10 A-B, 11 -B
//   acc_en              use accumulator as operand A
//   in_a, in_b          WIDTH-bit operands
//   out_valid/out_ready result handshake
//   g                   result
//   carry, ovf          adder carry-out and signed overflow
//   zero, neg           g == 0 and g[WIDTH-1]
//   op_count            results taken by the consumer, wraps modulo 2^CNT_W
module param_arith_unit #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s1,
  input  logic             s0,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [CNT_W-1:0] op_count
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_g;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH-1:0] w_low;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic             w_accept;
  logic             w_drain;

  assign w_a = acc_en ? r_acc : in_a;

  // Every op is mapped onto X + Y + cin so that a single adder serves all four.
  always_comb begin
    w_x   = w_a;
    w_y   = in_b;
    w_cin = 1'b0;
    case ({s1, s0})
      2'b00: w_y = '1;
      2'b01: w_y = in_b;
      2'b10: begin
        w_y   = ~in_b;
        w_cin = 1'b1;
      end
      default: begin
        w_x   = '0;
        w_y   = ~in_b;
        w_cin = 1'b1;
      end
    endcase
  end

  // The low slice is added separately to expose the carry into the MSB.
  assign w_low = {1'b0, w_x[WIDTH-2:0]} + {1'b0, w_y[WIDTH-2:0]}
               + {{(WIDTH-1){1'b0}}, w_cin};
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = w_low[WIDTH-1] ^ w_sum[WIDTH];

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_g         <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_g         <= w_sum[WIDTH-1:0];
        r_carry     <= w_sum[WIDTH];
        r_ovf       <= w_ovf;
        r_zero      <= (w_sum[WIDTH-1:0] == '0);
        r_neg       <= w_sum[WIDTH-1];
        r_acc       <= w_sum[WIDTH-1:0];
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
      if (w_drain) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid = r_out_valid;
  assign g         = r_g;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign op_count  = r_count;

endmodule

// File: tb/tb_param_arith_unit.sv
module tb_param_arith_unit;
  localparam int W = 3;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, s1, s0, acc_en, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, g;
  logic carry, ovf, zero, neg;
  logic [7:0] op_count;

  param_arith_unit #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s1(s1), .s0(s0), .acc_en(acc_en), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .g(g), .carry(carry),
    .ovf(ovf), .zero(zero), .neg(neg), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] g;
    logic c, o, z, n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_ov  = 0;
  int   m_acc = 0;
  int   m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t ref_op(input int op, input int a, input int b);
    exp_t e;
    int sa, sb, full, sr;
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    case (op)
      0: begin full = a + (M - 1);       sr = sa - 1;  end
      1: begin full = a + b;             sr = sa + sb; end
      2: begin full = a + (M - 1 - b) + 1; sr = sa - sb; end
      default: begin full = (M - 1 - b) + 1; sr = -sb; end
    endcase
    e.g = W'(full % M);
    e.c = (full >= M);
    e.o = (sr < -(M/2)) || (sr > M/2 - 1);
    e.z = 1'b0;
    e.n = 1'b0;
    return e;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic drive(input bit v, input bit rdy, input int op, input bit ae,
                       input int a, input int b, input bit ovr, input exp_t eo);
    exp_t e;
    bit acc, drn;
    logic [1:0] opv;
    opv = 2'(op);
    in_valid = v; out_ready = rdy; s1 = opv[1]; s0 = opv[0];
    acc_en = ae; in_a = W'(a); in_b = W'(b);
    #1;
    chk("in_ready", int'(in_ready), int'(!m_ov || rdy));
    acc = v && (!m_ov || rdy);
    drn = m_ov && rdy;
    e = ovr ? eo : ref_op(op, ae ? m_acc : a, b);
    e.z = (e.g == 0);
    e.n = e.g[W-1];
    @(posedge clk); #1;
    if (acc) begin
      q.push_back(e);
      m_acc = int'(e.g);
    end
    if (drn) m_cnt = (m_cnt + 1) % 256;
    m_ov = acc ? 1'b1 : (drn ? 1'b0 : m_ov);
  endtask

  // Monitor: compares the presented result against the queue head every cycle
  // and pops it when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("op_count", int'(op_count), m_cnt);
      if (out_valid && q.size() != 0) begin
        chk("g", int'(g), int'(q[0].g));
        chk("carry", int'(carry), int'(q[0].c));
        chk("ovf", int'(ovf), int'(q[0].o));
        chk("zero", int'(zero), int'(q[0].z));
        chk("neg", int'(neg), int'(q[0].n));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Directed vectors: op, acc_en, A, B, g, carry, ovf
  int dir[16][7] = '{
    '{0,0,0,0, 7,0,0}, '{0,0,1,0, 0,1,0}, '{0,0,5,0, 4,1,0},
    '{1,0,3,2, 5,0,1}, '{1,0,1,7, 0,1,0},
    '{2,0,0,0, 0,1,0}, '{2,0,0,1, 7,0,0}, '{2,0,3,6, 5,0,1},
    '{3,0,0,0, 0,1,0}, '{3,0,0,7, 1,0,0}, '{3,0,5,4, 4,0,1},
    '{1,0,1,1, 2,0,0}, '{1,1,7,1, 3,0,0}, '{0,1,6,5, 2,1,0},
    '{2,1,0,2, 0,1,0}, '{1,0,2,2, 4,0,1}
  };

  task automatic do_reset_check();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_g", int'(g), 0);
    chk("rst_flags", int'({carry, ovf, zero, neg}), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    exp_t e;
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s1 = 1'b0; s0 = 1'b0;
    acc_en = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset_check();
    rst_n = 1'b1;

    // Directed vectors, back-to-back with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      e = '0;
      e.g = W'(dir[i][4]); e.c = dir[i][5][0]; e.o = dir[i][6][0];
      drive(1, 1, dir[i][0], dir[i][1][0], dir[i][2], dir[i][3], 1, e);
    end

    // Backpressure: result held for 3 cycles while the source keeps offering.
    drive(1, 1, 1, 0, 2, 3, 0, '0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 6, 1, 0, '0);
    drive(1, 1, 1, 0, 6, 1, 0, '0);
    drive(0, 1, 0, 0, 0, 0, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), 0, '0);
    end

    // Bring the counter to 255 and then watch it wrap.
    guard = 0;
    while (m_cnt != 255 && guard < 600) begin
      drive(1, 1, int'($urandom_range(0, 3)), 1'b0,
            int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), 0, '0);
      guard++;
    end
    chk("cnt_reach_255", m_cnt, 255);
    if (!m_ov) drive(1, 0, 1, 0, 1, 1, 0, '0);
    drive(0, 1, 0, 0, 0, 0, 0, '0);
    chk("op_count_wrap", int'(op_count), 0);

    // Reset while a result is held and the source offers a beat.
    drive(1, 1, 1, 0, 3, 3, 0, '0);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    q.delete(); m_ov = 0; m_acc = 0; m_cnt = 0;
    do_reset_check();
    rst_n = 1'b1;

    // Accumulator must have been cleared: acc(0) + 3.
    e = '0; e.g = 3'd3;
    drive(1, 1, 1, 1, 7, 3, 1, e);
    drive(0, 1, 0, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
